// File: rtl/dsp_sop2_pkg.sv
// Shared widths and types for int_sop_2_dspchain users.
// Operand bundle type used by the chain scheduler skew lines.
package dsp_sop2_pkg;

  localparam int A_W      = 18;
  localparam int B_W      = 19;
  localparam int ACC_W    = 37;
  localparam int MODE_W   = 11;
  localparam int SOP2_LAT = 2;

  typedef struct packed {
    logic [A_W-1:0] ax;
    logic [B_W-1:0] ay;
    logic [A_W-1:0] bx;
    logic [B_W-1:0] by;
  } sop2_ops_t;

endpackage

// File: rtl/sop2_result_fifo.sv
// Show-ahead sync FIFO for chain results.
// Ports: push_i/data_i write, pop_i/valid_o/data_o read, count_o occupancy.
module sop2_result_fifo
  import dsp_sop2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [ACC_W-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [ACC_W-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [ACC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push_i && cnt_q == CW'(DEPTH))
  );

endmodule

// File: rtl/sop2_chain_sched.sv
// Scheduler for a cascade of sop2 units: operand skew, in-flight
// tracking, credit-gated result FIFO and chain mode register.
// Ports: in_* job handshake, ch_* chain side, out_* results, cfg_* mode.
module sop2_chain_sched
  import dsp_sop2_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_STAGES*A_W-1:0] in_ax,
  input  logic [NUM_STAGES*B_W-1:0] in_ay,
  input  logic [NUM_STAGES*A_W-1:0] in_bx,
  input  logic [NUM_STAGES*B_W-1:0] in_by,
  input  logic [ACC_W-1:0]          in_bias,
  output logic [NUM_STAGES*A_W-1:0] ch_ax,
  output logic [NUM_STAGES*B_W-1:0] ch_ay,
  output logic [NUM_STAGES*A_W-1:0] ch_bx,
  output logic [NUM_STAGES*B_W-1:0] ch_by,
  output logic [ACC_W-1:0]          ch_bias,
  output logic [MODE_W-1:0]         ch_mode,
  input  logic [ACC_W-1:0]          ch_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  input  logic                      cfg_we,
  input  logic [MODE_W-1:0]         cfg_mode,
  output logic                      cfg_err,
  output logic                      busy
);

  // Last stage result lands SOP2_LAT cycles after its operands,
  // which arrive NUM_STAGES-1 cycles after accept.
  localparam int PIPE = NUM_STAGES + SOP2_LAT - 1;
  localparam int CW   = $clog2(OUT_DEPTH + 1);

  logic              accept;
  logic              pop;
  logic              push;
  logic [CW-1:0]     credit_q, credit_d;
  logic [CW-1:0]     fifo_count;
  logic [PIPE-1:0]   vp_q;
  logic [ACC_W-1:0]  bias_q;
  logic [MODE_W-1:0] mode_q;
  logic              err_q;

  assign in_ready = !reset && (credit_q != '0);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign push     = vp_q[PIPE-1];
  assign busy     = (|vp_q) | accept;
  assign ch_bias  = bias_q;
  assign ch_mode  = mode_q;
  assign cfg_err  = err_q;

  assign credit_d = credit_q - CW'(accept) + CW'(pop);

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    sop2_ops_t op_in;
    // Idle slots carry zeros so the chain never sees stale operands.
    assign op_in = accept ? {in_ax[A_W*i +: A_W],
                             in_ay[B_W*i +: B_W],
                             in_bx[A_W*i +: A_W],
                             in_by[B_W*i +: B_W]} : '0;
    if (i == 0) begin : g_nodly
      assign ch_ax[0 +: A_W] = op_in.ax;
      assign ch_ay[0 +: B_W] = op_in.ay;
      assign ch_bx[0 +: A_W] = op_in.bx;
      assign ch_by[0 +: B_W] = op_in.by;
    end else begin : g_dly
      sop2_ops_t dly_q [i];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < i; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= op_in;
          for (int k = 1; k < i; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign ch_ax[A_W*i +: A_W] = dly_q[i-1].ax;
      assign ch_ay[B_W*i +: B_W] = dly_q[i-1].ay;
      assign ch_bx[A_W*i +: A_W] = dly_q[i-1].bx;
      assign ch_by[B_W*i +: B_W] = dly_q[i-1].by;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q <= CW'(OUT_DEPTH);
      vp_q     <= '0;
      bias_q   <= '0;
      mode_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      vp_q     <= {vp_q[PIPE-2:0], accept};
      bias_q   <= accept ? in_bias : '0;
      err_q    <= cfg_we & busy;
      if (cfg_we && !busy) mode_q <= cfg_mode;
    end
  end

  sop2_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (ch_result),
    .pop_i   (pop),
    .valid_o (out_valid),
    .data_o  (out_data),
    .count_o (fifo_count)
  );

  // Every credit is either free, in flight, or parked in the FIFO.
  a_credit_sum: assert property (
    @(posedge clk) disable iff (reset)
    int'(credit_q) + int'(fifo_count) + $countones(vp_q) == OUT_DEPTH
  );

endmodule

// File: tb/tb_sop2_chain_sched.sv
// Bench for sop2_chain_sched: chain stub, scoreboard, random+directed.
// Ports: none (top-level bench).
module tb_sop2_chain_sched;
  import dsp_sop2_pkg::*;

  localparam int NS    = 4;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid, in_ready;
  logic [NS*18-1:0]  in_ax, in_bx, ch_ax, ch_bx;
  logic [NS*19-1:0]  in_ay, in_by, ch_ay, ch_by;
  logic [36:0]       in_bias, ch_bias, ch_result, out_data;
  logic [10:0]       ch_mode, cfg_mode;
  logic              out_valid, out_ready;
  logic              cfg_we, cfg_err, busy;

  always #5 clk = ~clk;

  sop2_chain_sched #(.NUM_STAGES(NS), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ax(in_ax), .in_ay(in_ay), .in_bx(in_bx), .in_by(in_by),
    .in_bias(in_bias),
    .ch_ax(ch_ax), .ch_ay(ch_ay), .ch_bx(ch_bx), .ch_by(ch_by),
    .ch_bias(ch_bias), .ch_mode(ch_mode), .ch_result(ch_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
    .busy(busy)
  );

  // Chain stub: operands sampled at t, chainin added at t+1.
  logic [36:0] prod_q [NS];
  logic [36:0] sum_q  [NS];
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++)
      prod_q[i] <= 37'(64'(ch_ax[18*i +: 18]) * 64'(ch_ay[19*i +: 19])
                     + 64'(ch_bx[18*i +: 18]) * 64'(ch_by[19*i +: 19]));
    sum_q[0] <= prod_q[0] + ch_bias;
    for (int i = 1; i < NS; i++)
      sum_q[i] <= prod_q[i] + sum_q[i-1];
  end
  assign ch_result = sum_q[NS-1];

  typedef struct {
    logic [36:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vec = 0;
  int   miscmp = 0;
  bit   chk_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: bias plus all operand products, modulo 2^37.
  function automatic logic [36:0] ref_job();
    logic [63:0] s;
    s = 64'(in_bias);
    for (int i = 0; i < NS; i++)
      s += 64'(in_ax[18*i +: 18]) * 64'(in_ay[19*i +: 19])
         + 64'(in_bx[18*i +: 18]) * 64'(in_by[19*i +: 19]);
    return s[36:0];
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vec++;
        miscmp++;
        $display("FAIL unexpected_out: got %0h expected none", out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.data);
        if (chk_lat) chk("latency", 64'(cyc - mon_e.cyc), NS + 2);
      end
    end
  end

  task automatic rand_job();
    for (int i = 0; i < NS; i++) begin
      in_ax[18*i +: 18] = 18'($urandom);
      in_ay[19*i +: 19] = 19'($urandom);
      in_bx[18*i +: 18] = 18'($urandom);
      in_by[19*i +: 19] = 19'($urandom);
    end
    in_bias  = {5'($urandom), 32'($urandom)};
    in_valid = 1'b1;
  endtask

  task automatic issue(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      e.data = ref_job();
      e.cyc  = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || busy || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(n >= 300), 0);
  endtask

  task automatic fill_check(input string nm);
    int acc_n = 0;
    bit a;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rand_job();
      issue(a);
      acc_n += int'(a);
    end
    chk({nm, "_accepted"}, 64'(acc_n), DEPTH);
    @(negedge clk);
    chk({nm, "_ready_low"}, in_ready, 0);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    chk({nm, "_ready_back"}, in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    in_valid = 0; in_ax = '0; in_ay = '0; in_bx = '0; in_by = '0;
    in_bias = '0; out_ready = 0; cfg_we = 0; cfg_mode = '0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_ch_mode", ch_mode, 0);
    chk("rst_ch_bias", ch_bias, 0);
    chk("rst_ch_ax", ch_ax, 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single job: 4 stages of 1*1+1*1 plus bias 5 gives 13.
    out_ready = 1;
    chk_lat   = 1;
    in_ax = {NS{18'd1}}; in_ay = {NS{19'd1}};
    in_bx = {NS{18'd1}}; in_by = {NS{19'd1}};
    in_bias  = 37'd5;
    in_valid = 1;
    issue(a);
    chk("single_acc", a, 1);
    in_valid = 0;
    for (int k = 1; k <= NS + 2; k++) begin
      @(negedge clk);
      if (k < NS) begin
        chk("skew_ax", ch_ax[18*k +: 18], 1);
        chk("skew_by", ch_by[19*k +: 19], 1);
        chk("skew_prev_idle", ch_ax[18*(k-1) +: 18], 0);
      end
      if (k == 1) chk("bias_dly", ch_bias, 5);
      if (k == NS + 1) begin
        chk("ch_result", ch_result, 13);
        chk("early_valid", out_valid, 0);
      end
      if (k == NS + 2) begin
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 13);
      end
    end
    @(posedge clk);
    #1;
    drain();

    // Back-to-back: results k leave on consecutive cycles.
    for (int k = 0; k < 20; k++) begin
      in_ax = '0; in_ay = '0; in_bx = '0; in_by = '0; in_bias = '0;
      in_ax[17:0] = 18'(k);
      in_ay[18:0] = 19'd1;
      in_valid = 1;
      issue(a);
      chk("b2b_ready", a, 1);
    end
    drain();
    chk_lat = 0;

    fill_check("bp");

    in_ax = {NS{18'h3FFFF}}; in_ay = {NS{19'h7FFFF}};
    in_bx = {NS{18'h3FFFF}}; in_by = {NS{19'h7FFFF}};
    in_bias  = 37'h1F_FFFF_FFFF;
    in_valid = 1;
    issue(a);
    chk("max_acc", a, 1);
    drain();

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(3) != 0) rand_job();
      else in_valid = 0;
      out_ready = ($urandom_range(2) != 0);
      issue(a);
    end
    drain();

    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #1;
    cfg_we = 1; cfg_mode = 11'h155;
    @(posedge clk);
    #1;
    cfg_we = 0;
    @(negedge clk);
    chk("cfg_mode_wr", ch_mode, 11'h155);
    chk("cfg_no_err", cfg_err, 0);
    @(posedge clk);
    #1;
    rand_job();
    cfg_we = 1; cfg_mode = 11'h2AA;
    issue(a);
    chk("cfg_job_acc", a, 1);
    cfg_we = 0; in_valid = 0;
    @(negedge clk);
    chk("cfg_err_acc", cfg_err, 1);
    chk("cfg_kept_acc", ch_mode, 11'h155);
    @(posedge clk);
    #1;
    cfg_we = 1; cfg_mode = 11'h0F0;
    @(posedge clk);
    #1;
    cfg_we = 0;
    @(negedge clk);
    chk("cfg_err_fly", cfg_err, 1);
    chk("cfg_kept_fly", ch_mode, 11'h155);
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err, 0);
    @(posedge clk);
    #1;
    drain();

    // 3 in flight + 2 in FIFO, then a 1-cycle reset.
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      rand_job();
      issue(a);
      chk("pre_rst_acc", a, 1);
    end
    in_valid = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_fifo", out_valid, 1);
    @(posedge clk);
    #1;
    reset = 1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 0;
    out_ready = 1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready_back", in_ready, 1);
    chk("mid_rst_mode", ch_mode, 0);
    for (int k = 0; k < NS + 4; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", out_valid, 0);
    end
    @(posedge clk);
    #1;
    fill_check("rst_credit");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
